// File: rtl/codificador_prioridad_n.sv
// Registered N-to-log2(N) priority encoder: captures request pulses and offers one pending index at a time.
// Latency: a request seen at edge t is offered (valido=1) after edge t+1; back-to-back offers give one per cycle.
// Backpressure: Salida is frozen while valido && !listo; the pending register keeps capturing new requests.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   X           - request lines, level-sampled every cycle and OR-ed into the pending register
//   limpiar     - synchronous clear of pending requests and of the current offer (beats everything else)
//   listo       - consumer ready; a transfer happens on an edge where valido && listo
//   Salida      - offered index (holds its last value while valido=0)
//   valido      - Salida carries a valid pending index
//   pendientes  - pending-request register
//
// Build option: define CODIFICADOR_RR_EN for round-robin selection; otherwise the highest index always wins.
module codificador_prioridad_n #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         X,
    input  logic                 limpiar,
    input  logic                 listo,
    output logic [$clog2(N)-1:0] Salida,
    output logic                 valido,
    output logic [N-1:0]         pendientes
);

    localparam int W = $clog2(N);
    localparam logic [N-1:0] UNO = N'(1);

    typedef enum logic {
        ESPERA = 1'b0,
        OFRECE = 1'b1
    } estado_t;

    estado_t        estado;
    estado_t        estado_sig;
    logic [W-1:0]   salida_q;
    logic [W-1:0]   salida_sig;
    logic [N-1:0]   pend_q;
    logic [N-1:0]   pend_sig;
    logic [N-1:0]   pend_tras;
    logic [N-1:0]   mascara;
    logic           traspaso;
    logic [W-1:0]   sel_espera;
    logic [W-1:0]   sel_tras;

    // A transfer only counts when it is not overridden by limpiar.
    assign traspaso  = (estado == OFRECE) && listo && !limpiar;
    assign mascara   = traspaso ? (UNO << salida_q) : '0;
    // New requests are OR-ed in after the clear, so a re-request of the
    // index being serviced keeps its pending bit set.
    assign pend_tras = (pend_q & ~mascara) | X;
    assign pend_sig  = limpiar ? '0 : pend_tras;

`ifdef CODIFICADOR_RR_EN
    // Search downward from 'inicio', wrapping from 0 to N-1; first set bit wins.
    function automatic logic [W-1:0] sel_rr(input logic [N-1:0] p, input logic [W-1:0] inicio);
        logic [W-1:0] r;
        logic         hallado;
        int           idx;
        r       = inicio;
        hallado = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(inicio) - k;
            if (idx < 0) begin
                idx = idx + N;
            end
            if (!hallado && (|(p & (UNO << idx)))) begin
                r       = W'(idx);
                hallado = 1'b1;
            end
        end
        return r;
    endfunction

    // 'puntero' is where the next search starts, i.e. one below the last
    // transferred index. It starts at N-1 so the first search matches the
    // fixed-priority order.
    logic [W-1:0] puntero;
    logic [W-1:0] puntero_tras;

    assign puntero_tras = (salida_q == '0) ? W'(N - 1) : (salida_q - 1'b1);
    assign sel_espera   = sel_rr(pend_q, puntero);
    // The follow-up offer after a transfer already uses the advanced pointer.
    assign sel_tras     = sel_rr(pend_tras, puntero_tras);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            puntero <= W'(N - 1);
        end else if (traspaso) begin
            puntero <= puntero_tras;
        end
    end
`else
    // Highest set index wins.
    function automatic logic [W-1:0] sel_fija(input logic [N-1:0] p);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (|(p & (UNO << i))) begin
                r = W'(i);
            end
        end
        return r;
    endfunction

    assign sel_espera = sel_fija(pend_q);
    assign sel_tras   = sel_fija(pend_tras);
`endif

    // Next-state and offer logic.
    always_comb begin
        estado_sig = estado;
        salida_sig = salida_q;
        case (estado)
            ESPERA: begin
                // Only the registered pending set is considered here, which
                // gives the two-edge request-to-offer latency.
                if (!limpiar && (|pend_q)) begin
                    salida_sig = sel_espera;
                    estado_sig = OFRECE;
                end
            end
            OFRECE: begin
                if (limpiar) begin
                    estado_sig = ESPERA;
                end else if (listo) begin
                    if (|pend_tras) begin
                        salida_sig = sel_tras;
                    end else begin
                        estado_sig = ESPERA;
                    end
                end
                // !listo: offer frozen, higher-priority arrivals just queue up.
            end
            default: begin
                estado_sig = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= ESPERA;
            salida_q <= '0;
            pend_q   <= '0;
        end else begin
            estado   <= estado_sig;
            salida_q <= salida_sig;
            pend_q   <= pend_sig;
        end
    end

    assign Salida     = salida_q;
    assign valido     = (estado == OFRECE);
    assign pendientes = pend_q;

    // Offer must not move while the consumer is stalling.
    property p_salida_estable;
        @(posedge clk) disable iff (!rst_n)
            (valido && !listo && !limpiar) |=> $stable(Salida);
    endproperty
    a_salida_estable: assert property (p_salida_estable);

    // Codes above N-1 are never offered.
    property p_salida_rango;
        @(posedge clk) disable iff (!rst_n)
            valido |-> (int'(Salida) < N);
    endproperty
    a_salida_rango: assert property (p_salida_rango);

endmodule

// File: tb/tb_codificador_prioridad_n.sv
module tb_codificador_prioridad_n;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   x;
    logic           limpiar;
    logic           listo;
    logic [W-1:0]   salida;
    logic           valido;
    logic [N-1:0]   pendientes;

    int total = 0;
    int bad   = 0;
    int esperado[$];
    int seq6[4];

    always #5 clk = ~clk;

    codificador_prioridad_n #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .X          (x),
        .limpiar    (limpiar),
        .listo      (listo),
        .Salida     (salida),
        .valido     (valido),
        .pendientes (pendientes)
    );

    task automatic chk(input string nombre, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic reinicio();
        x       = '0;
        listo   = 1'b0;
        limpiar = 1'b0;
        rst_n   = 1'b0;
        paso();
        paso();
        rst_n   = 1'b1;
    endtask

    // Scoreboard monitor: every transfer the DUT performs must match the
    // next expected index queued by the stimulus.
    always @(negedge clk) begin
        if (rst_n && valido && listo && !limpiar) begin
            if (esperado.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: transfer of index %0d, expected none", salida);
            end else begin
                int e;
                e = esperado.pop_front();
                chk("sb_salida", int'(salida), e);
            end
        end
    end

    initial begin
`ifdef CODIFICADOR_RR_EN
        seq6 = '{7, 0, 7, 0};
`else
        seq6 = '{7, 7, 7, 7};
`endif
        // 1: reset with all requests high, then release and drain.
        rst_n   = 1'b0;
        x       = '1;
        listo   = 1'b0;
        limpiar = 1'b0;
        paso();
        paso();
        chk("rst_valido", valido, 0);
        chk("rst_salida", salida, 0);
        chk("rst_pend", pendientes, 0);
        rst_n = 1'b1;
        paso();
        chk("lat_e1_valido", valido, 0);
        chk("lat_e1_pend", pendientes, 8'hFF);
        paso();
        chk("lat_e2_valido", valido, 1);
        chk("lat_e2_salida", salida, 7);
        x     = '0;
        listo = 1'b1;
        for (int i = 7; i >= 0; i--) esperado.push_back(i);
        repeat (9) paso();
        chk("drain_valido", valido, 0);
        chk("drain_pend", pendientes, 0);
        listo = 1'b0;

        // 2: single pulse held under backpressure.
        reinicio();
        x = 8'h04;
        paso();
        x = '0;
        paso();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valido", valido, 1);
            chk("hold_salida", salida, 2);
            paso();
        end
        listo = 1'b1;
        esperado.push_back(2);
        paso();
        chk("pulse_done_valido", valido, 0);
        chk("pulse_done_pend", pendientes, 0);
        listo = 1'b0;

        // 3: burst with consumer always ready.
        reinicio();
        esperado.push_back(7);
        esperado.push_back(5);
        esperado.push_back(1);
        x     = 8'hA2;
        listo = 1'b1;
        paso();
        x = '0;
        chk("burst_e1_valido", valido, 0);
        paso();
        chk("burst_s7", salida, 7);
        chk("burst_v7", valido, 1);
        paso();
        chk("burst_s5", salida, 5);
        chk("burst_v5", valido, 1);
        paso();
        chk("burst_s1", salida, 1);
        chk("burst_v1", valido, 1);
        paso();
        chk("burst_end_valido", valido, 0);
        chk("burst_end_pend", pendientes, 0);
        listo = 1'b0;

        // 4: re-request during the transfer cycle wins over the clear.
        reinicio();
        x = 8'h08;
        paso();
        x = '0;
        paso();
        chk("setwin_offer", salida, 3);
        listo = 1'b1;
        x     = 8'h08;
        esperado.push_back(3);
        esperado.push_back(3);
        paso();
        chk("setwin_pend", pendientes, 8'h08);
        chk("setwin_salida", salida, 3);
        chk("setwin_valido", valido, 1);
        x = '0;
        paso();
        chk("setwin_end_valido", valido, 0);
        chk("setwin_end_pend", pendientes, 0);
        listo = 1'b0;

        // 5: limpiar discards pending, the offer and same-cycle requests.
        reinicio();
        x = 8'h5A;
        paso();
        x = '0;
        paso();
        chk("clr_pre_pend", pendientes, 8'h5A);
        chk("clr_pre_valido", valido, 1);
        chk("clr_pre_salida", salida, 6);
        limpiar = 1'b1;
        x       = 8'h01;
        paso();
        chk("clr_pend", pendientes, 0);
        chk("clr_valido", valido, 0);
        limpiar = 1'b0;
        x       = '0;
        paso();
        chk("clr_after_pend", pendientes, 0);
        paso();
        chk("clr_after_valido", valido, 0);

        // 6: two requests held high, consumer always ready.
        reinicio();
        x     = 8'h81;
        listo = 1'b1;
        for (int i = 0; i < 4; i++) esperado.push_back(seq6[i]);
        paso();
        paso();
        chk("hold81_0", salida, seq6[0]);
        paso();
        chk("hold81_1", salida, seq6[1]);
        paso();
        chk("hold81_2", salida, seq6[2]);
        paso();
        chk("hold81_3", salida, seq6[3]);
        paso();
        listo = 1'b0;
        x     = '0;
        chk("hold81_next", salida, 7);
        chk("hold81_valido", valido, 1);
        // Asynchronous reset in the middle of an offer.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valido", valido, 0);
        chk("arst_salida", salida, 0);
        chk("arst_pend", pendientes, 0);
        paso();
        rst_n = 1'b1;
        paso();
        chk("arst_after_valido", valido, 0);

        paso();
        paso();
        chk("sb_empty", esperado.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
